// File: rtl/sundial_pkg.sv
// Shared constants and types for the sundial time base.
// Speed selections map to the tod step applied on each sec_tick.
package sundial_pkg;

    localparam int SECS_PER_DAY = 86400;
    localparam int TOD_W        = 17;

    typedef enum logic [1:0] {
        SPD_1X,
        SPD_60X,
        SPD_600X,
        SPD_3600X
    } speed_t;

    function automatic logic [TOD_W-1:0] step_secs(speed_t s);
        logic [TOD_W-1:0] r;
        r = TOD_W'(1);
        unique case (s)
            SPD_1X:    r = TOD_W'(1);
            SPD_60X:   r = TOD_W'(60);
            SPD_600X:  r = TOD_W'(600);
            SPD_3600X: r = TOD_W'(3600);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/strobe_counter.sv
// Mod-MOD counter with enable and synchronous clear.
// wrap is high in the cycle whose enabled edge returns the count to 0.
module strobe_counter #(
    parameter int MOD = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/timebase_controller.sv
// Clock-enable time base: pixel, ms and sec strobes plus time of day.
// UI loads of tod take priority over the per-second advance.
module timebase_controller
    import sundial_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int PIX_DIV       = 4,
    parameter int TICK_HZ       = 1000,
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       speed_sel,
    input  logic             set_valid,
    input  logic [TOD_W-1:0] set_tod,
    output logic             set_ready,
    output logic             set_err,
    output logic             pix_en,
    output logic             ms_tick,
    output logic             sec_tick,
    output logic [TOD_W-1:0] tod,
    output logic             day_wrap
);

    localparam int MS_DIV = CLK_HZ / TICK_HZ;
    localparam logic [TOD_W:0] DAY = SECS_PER_DAY[TOD_W:0];
    localparam logic [TOD_W-1:0] TOD_MAX = TOD_W'(SECS_PER_DAY - 1);

    logic pix_wrap;
    logic ms_wrap;
    logic sec_wrap;
    logic load;
    logic in_range;
    logic load_ok;
    logic [TOD_W:0] sum;
    logic over;
    logic [TOD_W-1:0] tod_step;

    assign load     = set_valid && set_ready;
    assign in_range = (set_tod <= TOD_MAX);
    assign load_ok  = load && in_range;

    strobe_counter #(.MOD(PIX_DIV)) u_pix (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (1'b1),
        .clr    (1'b0),
        .wrap   (pix_wrap)
    );

    // A good load realigns the ms/sec phase to the load edge.
    strobe_counter #(.MOD(MS_DIV)) u_ms (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (run),
        .clr    (load_ok),
        .wrap   (ms_wrap)
    );

    strobe_counter #(.MOD(TICKS_PER_SEC)) u_sec (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (ms_wrap),
        .clr    (load_ok),
        .wrap   (sec_wrap)
    );

    always_comb begin
        sum      = {1'b0, tod} + {1'b0, step_secs(speed_t'(speed_sel))};
        over     = (sum >= DAY);
        tod_step = over ? TOD_W'(sum - DAY) : sum[TOD_W-1:0];
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pix_en    <= 1'b0;
            ms_tick   <= 1'b0;
            sec_tick  <= 1'b0;
            set_ready <= 1'b1;
            set_err   <= 1'b0;
            day_wrap  <= 1'b0;
            tod       <= '0;
        end else begin
            pix_en    <= pix_wrap;
            ms_tick   <= ms_wrap;
            sec_tick  <= sec_wrap;
            set_ready <= !load;
            set_err   <= load && !in_range;
            day_wrap  <= 1'b0;
            if (load_ok) begin
                tod <= set_tod;
            end else if (sec_wrap) begin
                tod      <= tod_step;
                day_wrap <= over;
            end
        end
    end

endmodule

// File: tb/tb_timebase_controller.sv
// Directed bench for timebase_controller with scaled dividers.
// 10 clocks per ms_tick, 5 ms_ticks per sec_tick, pix_en every 4 clocks.
module tb_timebase_controller;

    logic        clk_in;
    logic        reset;
    logic        run;
    logic [1:0]  speed_sel;
    logic        set_valid;
    logic [16:0] set_tod;
    logic        set_ready;
    logic        set_err;
    logic        pix_en;
    logic        ms_tick;
    logic        sec_tick;
    logic [16:0] tod;
    logic        day_wrap;

    int total;
    int passed;

    timebase_controller #(
        .CLK_HZ        (1000),
        .PIX_DIV       (4),
        .TICK_HZ       (100),
        .TICKS_PER_SEC (5)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .run       (run),
        .speed_sel (speed_sel),
        .set_valid (set_valid),
        .set_tod   (set_tod),
        .set_ready (set_ready),
        .set_err   (set_err),
        .pix_en    (pix_en),
        .ms_tick   (ms_tick),
        .sec_tick  (sec_tick),
        .tod       (tod),
        .day_wrap  (day_wrap)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_sec(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (sec_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ms(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (ms_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b0;
        speed_sel = 2'd0;
        set_valid = 1'b0;
        set_tod = '0;
        repeat (10) step();
        total++;
        if ({pix_en, ms_tick, sec_tick, day_wrap, set_err} !== 5'b0) begin
            $display("FAIL reset_strobes got=%b exp=00000",
                     {pix_en, ms_tick, sec_tick, day_wrap, set_err});
        end else passed++;
        total++;
        if (set_ready !== 1'b1) begin
            $display("FAIL reset_ready got=%b exp=1", set_ready);
        end else passed++;
        total++;
        if (tod !== 17'd0) begin
            $display("FAIL reset_tod got=%0d exp=0", tod);
        end else passed++;
    endtask

    task automatic test_dividers();
        logic [2:0] exp_s;
        reset = 1'b0;
        run = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            exp_s = {k % 4 == 0, k % 10 == 0, k % 50 == 0};
            total++;
            if ({pix_en, ms_tick, sec_tick} !== exp_s ||
                tod !== 17'(k / 50)) begin
                $display("FAIL div k=%0d strobes=%b exp=%b tod=%0d exp=%0d",
                         k, {pix_en, ms_tick, sec_tick}, exp_s,
                         tod, k / 50);
            end else passed++;
        end
    endtask

    task automatic test_load_wrap();
        int n;
        total++;
        if (set_ready !== 1'b1) begin
            $display("FAIL lw_ready_pre got=%b exp=1", set_ready);
        end else passed++;
        set_valid = 1'b1;
        set_tod = 17'd86399;
        speed_sel = 2'd0;
        step();
        set_valid = 1'b0;
        total++;
        if (set_ready !== 1'b0 || tod !== 17'd86399) begin
            $display("FAIL lw_load ready=%b exp=0 tod=%0d exp=86399",
                     set_ready, tod);
        end else passed++;
        step();
        total++;
        if (set_ready !== 1'b1) begin
            $display("FAIL lw_ready_back got=%b exp=1", set_ready);
        end else passed++;
        wait_sec(n);
        total++;
        if (n !== 49 || tod !== 17'd0 || day_wrap !== 1'b1) begin
            $display("FAIL lw_wrap cycles=%0d exp=49 tod=%0d exp=0 dw=%b exp=1",
                     n, tod, day_wrap);
        end else passed++;
        step();
        total++;
        if (day_wrap !== 1'b0 || tod !== 17'd0) begin
            $display("FAIL lw_after dw=%b exp=0 tod=%0d exp=0", day_wrap, tod);
        end else passed++;
    endtask

    task automatic test_speed();
        int n;
        repeat (23) step();
        set_valid = 1'b1;
        set_tod = 17'd86000;
        speed_sel = 2'd3;
        step();
        set_valid = 1'b0;
        total++;
        if (tod !== 17'd86000) begin
            $display("FAIL spd_load got=%0d exp=86000", tod);
        end else passed++;
        wait_sec(n);
        total++;
        if (n !== 50 || tod !== 17'd3200 || day_wrap !== 1'b1) begin
            $display("FAIL spd_step cycles=%0d exp=50 tod=%0d exp=3200 dw=%b exp=1",
                     n, tod, day_wrap);
        end else passed++;
    endtask

    task automatic test_bad_load();
        int n;
        speed_sel = 2'd0;
        set_valid = 1'b1;
        set_tod = 17'd90000;
        step();
        set_valid = 1'b0;
        total++;
        if (set_err !== 1'b1 || set_ready !== 1'b0 || tod !== 17'd3200) begin
            $display("FAIL bad_load err=%b exp=1 ready=%b exp=0 tod=%0d exp=3200",
                     set_err, set_ready, tod);
        end else passed++;
        step();
        total++;
        if (set_err !== 1'b0 || set_ready !== 1'b1) begin
            $display("FAIL bad_after err=%b exp=0 ready=%b exp=1",
                     set_err, set_ready);
        end else passed++;
        wait_sec(n);
        total++;
        if (n !== 48 || tod !== 17'd3201 || day_wrap !== 1'b0) begin
            $display("FAIL bad_phase cycles=%0d exp=48 tod=%0d exp=3201 dw=%b exp=0",
                     n, tod, day_wrap);
        end else passed++;
    endtask

    task automatic test_load_on_sec();
        int n;
        repeat (49) step();
        set_valid = 1'b1;
        set_tod = 17'd500;
        step();
        set_valid = 1'b0;
        total++;
        if (sec_tick !== 1'b1 || tod !== 17'd500 || day_wrap !== 1'b0) begin
            $display("FAIL los_edge sec=%b exp=1 tod=%0d exp=500 dw=%b exp=0",
                     sec_tick, tod, day_wrap);
        end else passed++;
        wait_ms(n);
        total++;
        if (n !== 10 || tod !== 17'd500) begin
            $display("FAIL los_ms cycles=%0d exp=10 tod=%0d exp=500", n, tod);
        end else passed++;
    endtask

    task automatic test_run_pause();
        int n;
        int bad;
        int pix;
        bad = 0;
        pix = 0;
        repeat (3) step();
        run = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            step();
            if (ms_tick || sec_tick || day_wrap || tod !== 17'd500) bad++;
            if (k <= 36 && pix_en) pix++;
        end
        total++;
        if (bad !== 0) begin
            $display("FAIL pause_frozen got=%0d bad cycles exp=0", bad);
        end else passed++;
        total++;
        if (pix !== 9) begin
            $display("FAIL pause_pix got=%0d exp=9", pix);
        end else passed++;
        run = 1'b1;
        wait_ms(n);
        total++;
        if (n !== 7) begin
            $display("FAIL resume_ms cycles=%0d exp=7", n);
        end else passed++;
        wait_sec(n);
        total++;
        if (n !== 30 || tod !== 17'd501) begin
            $display("FAIL resume_sec cycles=%0d exp=30 tod=%0d exp=501", n, tod);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int pix;
        set_valid = 1'b1;
        set_tod = 17'd1000;
        step();
        set_valid = 1'b0;
        total++;
        if (tod !== 17'd1000 || set_ready !== 1'b0) begin
            $display("FAIL rm_pre tod=%0d exp=1000 ready=%b exp=0", tod, set_ready);
        end else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (tod !== 17'd0 || set_ready !== 1'b1 ||
            {pix_en, ms_tick, sec_tick, day_wrap, set_err} !== 5'b0) begin
            $display("FAIL rm_async tod=%0d exp=0 ready=%b exp=1 strobes=%b exp=00000",
                     tod, set_ready,
                     {pix_en, ms_tick, sec_tick, day_wrap, set_err});
        end else passed++;
        step();
        step();
        reset = 1'b0;
        pix = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (pix_en) pix = pix + k;
        end
        total++;
        if (pix !== 4 || tod !== 17'd0) begin
            $display("FAIL rm_release pixsum=%0d exp=4 tod=%0d exp=0", pix, tod);
        end else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_dividers();
        test_load_wrap();
        test_speed();
        test_bad_load();
        test_load_on_sec();
        test_run_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timebase_controller.md
# timebase_controller

Central time-base sequencer for the sundial FPGA design. It runs from the 100 MHz board clock and produces single-cycle clock-enable strobes: a 25 MHz pixel enable for the VGA path, a 1 kHz tick and a 1 Hz tick. From the 1 Hz tick it maintains the simulated time of day that drives the sun-position and shadow logic. It replaces derived clocks with enables, so every downstream block stays on `clk_in`. It also arbitrates time-of-day loads from the UI against normal advancement.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency.
- `PIX_DIV`, 4, clk_in cycles per pix_en pulse (≥2).
- `TICK_HZ`, 1000, ms_tick rate. CLK_HZ/TICK_HZ must be an integer ≥2.
- `TICKS_PER_SEC`, 1000, ms_ticks per sec_tick.

Ports:
- `clk_in`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 = time advances; 0 = ms/sec counters and tod frozen.
- `speed_sel`  in  2  tod step per sec_tick: 0→1 s, 1→60 s, 2→600 s, 3→3600 s.
- `set_valid`  in  1  time-of-day load request.
- `set_tod`  in  17  requested time, in seconds (0..86399).
- `set_ready`  out  1  load can be accepted this cycle.
- `set_err`  out  1  one-cycle pulse: accepted load was out of range and was discarded.
- `pix_en`  out  1  one-cycle strobe every PIX_DIV cycles.
- `ms_tick`  out  1  one-cycle strobe every CLK_HZ/TICK_HZ cycles while run=1.
- `sec_tick`  out  1  one-cycle strobe every TICKS_PER_SEC ms_ticks.
- `tod`  out  17  time of day in seconds, 0..86399.
- `day_wrap`  out  1  one-cycle pulse when tod wraps past 86399.

## Operation
- **Reset:** all outputs are 0 except set_ready=1. All counters are 0. tod=0.
- **Pixel divider:** free-running mod-PIX_DIV counter, independent of `run` and of loads. pix_en=1 when the counter equals PIX_DIV-1.
- **ms divider:** mod-(CLK_HZ/TICK_HZ) counter. It increments only when run=1. ms_tick=1 on the cycle the counter wraps.
- **sec divider:** mod-TICKS_PER_SEC counter. It increments on ms_tick. sec_tick=1 on the same cycle as the ms_tick that wraps it.
- **tod advance on sec_tick:**
  - sum = tod + step(speed_sel), computed 18 bits wide.
  - If sum ≥ 86400: tod ← sum − 86400 and day_wrap=1. Otherwise tod ← sum.
- **Load handshake:**
  - A transfer occurs when set_valid && set_ready.
  - After an accepted transfer, set_ready=0 for exactly one cycle, then returns to 1.
  - If set_tod ≤ 86399: tod ← set_tod, and the ms and sec counters clear to 0 (phase realignment).
  - If set_tod > 86399: tod, ms and sec counters are unchanged, and set_err=1 on the next cycle.
- **Simultaneous load and sec_tick edge:** the load wins. tod takes set_tod. sec_tick still pulses, but no step is applied and day_wrap=0.
- **run=0:** the ms/sec counters hold their values. ms_tick, sec_tick and day_wrap stay 0. Loads are still accepted.
- **speed_sel changes** take effect at the next sec_tick. They never cause a partial step.

## Timing
- All outputs are registered, with no combinational input→output paths.
- pix_en first asserts on cycle PIX_DIV after reset deasserts, then every PIX_DIV cycles.
- ms_tick first asserts CLK_HZ/TICK_HZ cycles after reset release with run=1.
- tod, day_wrap and sec_tick update on the same clock edge. The new tod is visible in the cycle where sec_tick=1.
- A load accepted at edge N shows the new tod in cycle N+1. The ms counter restarts from 0 at N+1.
- Reset asserted mid-operation clears everything immediately (asynchronous). Release is sampled on clk_in.

## Structure
- Shared package `sundial_pkg`:
  - `SECS_PER_DAY=86400`
  - `TOD_W=17`
  - `speed_t` enum (SPD_1X, SPD_60X, SPD_600X, SPD_3600X)
  - step lookup function
- One sub-module, `strobe_counter #(MOD)`: a mod-N counter with an enable input, a synchronous clear input and a wrap-strobe output. Instantiate it three times (pixel, ms, sec).
- The tod/load logic stays at the top level.

## Test plan
Use scaled parameters: CLK_HZ=1000, TICK_HZ=100, TICKS_PER_SEC=5, PIX_DIV=4.
- Reset for 10 cycles, then run=1 → pix_en every 4 cycles, ms_tick every 10 cycles, sec_tick every 50 cycles; tod goes 0→1→2.
- Load set_tod=86399 with speed_sel=0, wait one sec_tick → tod=0 with a day_wrap pulse; set_ready low for one cycle after the load.
- speed_sel=3 with tod=86000 → next sec_tick gives tod=3200 and day_wrap=1.
- set_tod=90000 accepted → tod unchanged; set_err pulses once on the next cycle.
- Load asserted on the sec_tick edge with set_tod=500 → tod=500, no step applied, ms counter realigned (next ms_tick 10 cycles later).
- run=0 for 37 cycles mid-count → no ms_tick, sec_tick or tod change; pix_en continues; counting resumes from the held phase. Assert reset mid-run → all outputs cleared immediately.
